// File: rtl/pc_pkg.sv
// Shared types and control decode for the program-sequencing unit.
// The decode function encodes the per-cycle priority of the sequencer controls.
package pc_pkg;

   typedef enum logic [2:0] {
      SEQ,
      BR_REL,
      BR_ABS,
      CALL,
      RET,
      HOLD
   } ctl_e;

   // Priority: stall, return, call, relative branch, absolute branch, sequential.
   function automatic ctl_e decode_ctl(
      input logic stall,
      input logic ret_en,
      input logic call_en,
      input logic branch_en,
      input logic reljump_en,
      input logic absjump_en
   );
      ctl_e ctl;
      if (stall)
         ctl = HOLD;
      else if (ret_en)
         ctl = RET;
      else if (call_en)
         ctl = CALL;
      else if (branch_en && reljump_en)
         ctl = BR_REL;
      else if (branch_en && absjump_en)
         ctl = BR_ABS;
      else
         ctl = SEQ;
      return ctl;
   endfunction

endpackage

// File: rtl/pc_stack_seq_ret_stack.sv
// Register-array return-address LIFO; top of stack is readable combinationally.
// Pushes while full and pops while empty are ignored; pop wins if both are requested.
module ret_stack #(
   parameter int D     = 12,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [D-1:0]  push_data,
   output logic [D-1:0]  top,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [D-1:0]  mem [DEPTH];
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] top_idx;
   logic          do_pop;
   logic          do_push;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !full && !do_pop;
   assign wr_idx  = IW'(count);
   assign top_idx = IW'(count - CW'(1));
   assign top     = mem[top_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (do_pop)
         count <= count - CW'(1);
      else if (do_push)
         count <= count + CW'(1);
   end

   // Entries need no reset; only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/pc_stack_seq.sv
// Program sequencer: next-PC selection for sequential, branch, call and return flow,
// backed by a hardware return stack with sticky overflow/underflow flags.
module pc_stack_seq
   import pc_pkg::*;
#(
   parameter int            D          = 12,
   parameter int            DEPTH      = 4,
   parameter logic [D-1:0]  RESET_ADDR = '0,
   localparam int           CW         = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          branch_en,
   input  logic          reljump_en,
   input  logic          absjump_en,
   input  logic          call_en,
   input  logic          ret_en,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic [CW-1:0] sp_count,
   output logic          stk_ovf,
   output logic          stk_unf
);

   ctl_e         ctl;
   logic [D-1:0] pc_inc;
   logic [D-1:0] stk_top;
   logic         stk_full;
   logic         stk_empty;

   assign ctl    = decode_ctl(stall, ret_en, call_en, branch_en, reljump_en, absjump_en);
   assign pc_inc = prog_ctr + D'(1);

   ret_stack #(
      .D     (D),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (ctl == CALL),
      .pop       (ctl == RET),
      .push_data (pc_inc),
      .top       (stk_top),
      .count     (sp_count),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // A call on a full stack still jumps; only the return address is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prog_ctr <= RESET_ADDR;
         stk_ovf  <= 1'b0;
         stk_unf  <= 1'b0;
      end else begin
         case (ctl)
            HOLD: prog_ctr <= prog_ctr;
            RET: begin
               if (stk_empty) begin
                  prog_ctr <= pc_inc;
                  stk_unf  <= 1'b1;
               end else begin
                  prog_ctr <= stk_top;
               end
            end
            CALL: begin
               prog_ctr <= target;
               if (stk_full)
                  stk_ovf <= 1'b1;
            end
            BR_REL:  prog_ctr <= prog_ctr + target;
            BR_ABS:  prog_ctr <= target;
            default: prog_ctr <= pc_inc;
         endcase
      end
   end

endmodule

// File: doc/pc_stack_seq.md
# pc_stack_seq

Parametrised program-sequencing unit; successor to the single-channel program counter. It adds:
- configurable address width;
- a hardware call/return stack of configurable depth;
- a stall input;
- sticky stack-error flags.

It sits between the control decoder and instruction memory. It drives the fetch address every cycle and resolves branches, calls and returns in one cycle.

## Interface
Parameters:
- D, 12, address width in bits (prog_ctr, target, stack entries)
- DEPTH, 4, return-stack entries; legal range 1..16
- RESET_ADDR, 0, value loaded into prog_ctr on reset (D bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; clears all state while low
- stall  input  1  hold all state this cycle
- branch_en  input  1  branch taken this cycle; qualifies reljump_en/absjump_en
- reljump_en  input  1  relative jump: prog_ctr + target
- absjump_en  input  1  absolute jump: prog_ctr = target
- call_en  input  1  push return address, jump absolute to target
- ret_en  input  1  pop return address into prog_ctr
- target  input  D  jump offset (two's complement) or absolute address
- prog_ctr  output  D  current fetch address
- sp_count  output  $clog2(DEPTH+1)  number of valid stack entries
- stk_ovf  output  1  sticky: call attempted with stack full
- stk_unf  output  1  sticky: return attempted with stack empty

## Operation
- Reset values: prog_ctr = RESET_ADDR, sp_count = 0, stk_ovf = 0, stk_unf = 0, stack contents don't-care.
- Per-cycle priority, highest first: reset, stall, ret_en, call_en, branch_en, sequential.
- stall=1: prog_ctr, stack, sp_count and flags all hold. All other controls are ignored.
- ret_en=1, stack non-empty: prog_ctr <= top entry; sp_count decrements.
- ret_en=1, stack empty: prog_ctr <= prog_ctr+1; stk_unf <= 1; sp_count stays 0.
- call_en=1 (ret_en=0), stack not full: push prog_ctr+1; prog_ctr <= target; sp_count increments.
- call_en=1, stack full (sp_count==DEPTH): jump still taken (prog_ctr <= target); push dropped; existing entries unchanged; stk_ovf <= 1.
- ret_en and call_en both high: return only; call ignored; no flag set.
- branch_en=1 with reljump_en=1: prog_ctr <= prog_ctr + target, mod 2^D. Negative target steps backwards.
- branch_en=1 with absjump_en=1 only: prog_ctr <= target.
- branch_en=1 with neither mode: prog_ctr <= prog_ctr+1. This differs from the predecessor, which held the PC.
- branch_en=0: prog_ctr <= prog_ctr+1, wrapping from 2^D-1 to 0.
- reljump_en/absjump_en are ignored without branch_en.
- All additions are D bits, modular, with carry discarded. Return addresses also wrap (call at 2^D-1 pushes 0).
- Flags are sticky and clear only on reset.

## Timing
- Single-cycle: the effect of the controls sampled at edge N is visible on prog_ctr after edge N.
- prog_ctr, sp_count and the flags are registered outputs. There is no combinational path from input to output.
- The stack top is readable in the same cycle ret_en is asserted. There is no pop latency.
- Back-to-back call/ret in consecutive cycles is legal and must be exact, with no bubble.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. The first update after deassertion occurs at the first rising edge with reset high.

## Structure
- Shared package pc_pkg:
  - ctl_e enum (SEQ, BR_REL, BR_ABS, CALL, RET, HOLD);
  - the priority-decode function mapping inputs to ctl_e.
- Sub-module ret_stack:
  - parameters D and DEPTH;
  - inputs push, pop, push_data;
  - outputs top, count, full, empty;
  - register-array LIFO with the same async active-low reset on count;
  - push while full is ignored internally.
- Top level: decode, next-PC mux, flag logic.

## Test plan
- Reset then 5 free-running cycles -> prog_ctr 0,1,2,3,4,5; sp_count 0; flags 0.
- D=12, prog_ctr=0x010, branch_en=1, reljump_en=1, target=0xFFC -> prog_ctr=0x00C. Then absjump_en with target=0xFFF, then one sequential cycle -> prog_ctr=0xFFF, then 0x000.
- Nested calls at 0x020 (target 0x100) and 0x101 (target 0x200), then two rets -> prog_ctr 0x100, 0x200, 0x102, 0x021; sp_count 1,2,1,0.
- DEPTH=4: five calls -> fifth jumps to target, sp_count stays 4, stk_ovf=1. Four rets then pop correct addresses; a fifth ret -> prog_ctr+1, stk_unf=1.
- stall=1 held 3 cycles with call_en=1 -> prog_ctr and sp_count unchanged. Release -> call executes once.
- Reset pulled low asynchronously between edges during a call sequence -> prog_ctr=RESET_ADDR and sp_count=0 before the next edge; flags cleared.
